// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder built around one full-adder cell (obfa) that is
//   evaluated once per clock. A start strobe captures a, b and cin. The sum is
//   then formed LSB-first over WIDTH cycles with a registered carry. done
//   pulses for one cycle when sum and cout are ready.
//
//   Optional feature macro: SERIAL_ADD_OVF_EN
//     defined   -> adds the ovf output (two's-complement signed overflow)
//     undefined -> no ovf port and no ovf register
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int                CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic             accept;
   logic             last_bit;
   logic             fa_s;
   logic             fa_c;
   logic [WIDTH-1:0] sum_shifted;

   // One-bit full adder; returns {carry_out, sum_bit}.
   function automatic logic [1:0] obfa(input logic x, input logic y, input logic ci);
      logic s;
      logic co;
      s  = x ^ y ^ ci;
      co = (x & y) | (x & ci) | (y & ci);
      return {co, s};
   endfunction

   assign {fa_c, fa_s} = obfa(a_sr[0], b_sr[0], carry);
   assign last_bit     = (cnt == LAST);

   // The new sum bit enters at the MSB so that after WIDTH shifts the LSB
   // computed first has reached bit 0.
   generate
      if (WIDTH == 1) begin : g_sum_w1
         assign sum_shifted = fa_s;
      end else begin : g_sum_wn
         assign sum_shifted = {fa_s, sum[WIDTH-1:1]};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and status outputs. A start in DONE is taken at once,
   // so back-to-back operations have no idle gap.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture on accept, then one bit per cycle while running.
   // sum and cout are never touched outside RUN, so they hold after done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= b;
         carry <= cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         carry <= fa_c;
         sum   <= sum_shifted;
         cnt   <= cnt + CNT_W'(1);
         if (last_bit) begin
            cout <= fa_c;
         end
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   // Signed overflow: on the last bit, carry still holds the carry into the
   // MSB and fa_c is the carry out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (accept) begin
         ovf <= 1'b0;
      end else if (state == RUN && last_bit) begin
         ovf <= carry ^ fa_c;
      end
   end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Directed bench for serial_adder_ctrl (WIDTH=8). Expected results are
//   pushed to a scoreboard queue when an operation is launched. They are
//   popped and compared when done is seen. Define SERIAL_ADD_OVF_EN to also
//   cover the ovf output.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   int checks   = 0;
   int failures = 0;

   // {ovf, cout, sum}
   logic [W+1:0] sb[$];

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive a start request with its operands and record the expected result.
   task automatic launch(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
      logic [W:0] s;
      logic       v;
      s = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
      v = (xa[W-1] == xb[W-1]) && (s[W-1] != xa[W-1]);
      a     = xa;
      b     = xb;
      cin   = xc;
      start = 1'b1;
      sb.push_back({v, s});
   endtask

   // Wait (bounded) for done after a launch. Latency, busy length and result
   // are checked. With glitch=1, start is pulsed at cycles 3 and 5 of the
   // operation. Operands are scrambled every cycle while the adder is busy.
   // Returns at the falling edge where done is seen, with start still low.
   task automatic finish_op(input string tag, input bit glitch);
      int           cyc;
      int           busy_cyc;
      bit           seen;
      logic [W+1:0] exp;
      cyc      = 0;
      busy_cyc = 0;
      seen     = 1'b0;
      while (!seen && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy) busy_cyc++;
            start = glitch && (cyc == 3 || cyc == 5);
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
         end
      end
      check({tag, "_latency"}, cyc, W + 1);
      check({tag, "_busy_cycles"}, busy_cyc, W);
      check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
      check({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
         exp = sb.pop_front();
         check({tag, "_sum"}, {24'd0, sum}, {24'd0, exp[W-1:0]});
         check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp[W]});
`ifdef SERIAL_ADD_OVF_EN
         check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp[W+1]});
`endif
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_sum", {24'd0, sum}, 0);
      check("rst_cout", {31'd0, cout}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // T1
      launch(8'h5A, 8'h33, 1'b0);
      finish_op("t1", 1'b0);
      check("t1_sum_const", {24'd0, sum}, 32'h8D);
      @(negedge clk);
      check("t1_done_one_cycle", {31'd0, done}, 0);
      check("t1_sum_held", {24'd0, sum}, 32'h8D);

      // T2
      @(negedge clk);
      launch(8'hFF, 8'h01, 1'b0);
      finish_op("t2a", 1'b0);
      check("t2a_cout_const", {31'd0, cout}, 1);
      @(negedge clk);
      launch(8'hFF, 8'hFF, 1'b1);
      finish_op("t2b", 1'b0);
      check("t2b_sum_const", {24'd0, sum}, 32'hFF);

      // T3: extra starts while busy are ignored
      @(negedge clk);
      launch(8'h12, 8'h34, 1'b0);
      finish_op("t3", 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_single_done", {31'd0, done}, 0);
         check("t3_idle_busy", {31'd0, busy}, 0);
      end

      // T4: start held in DONE reloads at once
      @(negedge clk);
      launch(8'h40, 8'h05, 1'b1);
      finish_op("t4a", 1'b0);
      launch(8'h01, 8'h02, 1'b0);
      check("t4_prior_visible", {24'd0, sum}, 32'h46);
      finish_op("t4b", 1'b0);
      check("t4b_sum_const", {24'd0, sum}, 32'h03);

      // T5: reset in the middle of an operation
      @(negedge clk);
      launch(8'h0F, 8'h01, 1'b0);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t5_busy", {31'd0, busy}, 0);
      check("t5_done", {31'd0, done}, 0);
      check("t5_sum", {24'd0, sum}, 0);
      check("t5_cout", {31'd0, cout}, 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("t5_no_done", {31'd0, done}, 0);
      end
      launch(8'h0F, 8'h01, 1'b0);
      finish_op("t5_fresh", 1'b0);
      check("t5_fresh_const", {24'd0, sum}, 32'h10);

`ifdef SERIAL_ADD_OVF_EN
      // T6
      @(negedge clk);
      launch(8'h7F, 8'h01, 1'b0);
      finish_op("t6a", 1'b0);
      check("t6a_ovf_const", {31'd0, ovf}, 1);
      @(negedge clk);
      launch(8'hFF, 8'h01, 1'b0);
      finish_op("t6b", 1'b0);
      check("t6b_ovf_const", {31'd0, ovf}, 0);
`endif

      // Random operands, chained back to back
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         launch(W'($urandom), W'($urandom), 1'($urandom));
         finish_op("rnd", 1'b0);
      end
      start = 1'b0;
      @(negedge clk);

      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
